// File: rtl/regfile_pkg.sv
// Shared widths and constants for the architectural register file and its rename table.
package regfile_pkg;
    localparam int REG_NUM = 32;
    localparam int NAME_W  = 5;
    localparam int NICK_W  = 5;
    localparam int DATA_W  = 32;

    localparam logic [NICK_W-1:0] ZERO_NICK = '0;
endpackage

// File: rtl/regfile_lookup.sv
// Operand select: 0-cycle combinational; returns committing data, producer nick, or stored value.
// No backpressure; outputs are valid every cycle.
module regfile_lookup
    import regfile_pkg::*;
(
    input  logic [NAME_W-1:0] regnm,
    input  logic              cm_en,
    input  logic [NAME_W-1:0] cm_regnm,
    input  logic [NICK_W-1:0] cm_nick,
    input  logic [DATA_W-1:0] cm_dt,
    input  logic              reg_busy,
    input  logic [NICK_W-1:0] reg_nick,
    input  logic [DATA_W-1:0] reg_dt,
    output logic              busy,
    output logic [NICK_W-1:0] nick,
    output logic [DATA_W-1:0] dt
);
    always_comb begin
        busy = 1'b0;
        nick = ZERO_NICK;
        dt   = '0;
        if (regnm != '0) begin
            // The producer is committing this cycle: forward its data instead of waiting.
            if (cm_en && cm_regnm == regnm && reg_busy && reg_nick == cm_nick) begin
                dt = cm_dt;
            end else if (reg_busy) begin
                busy = 1'b1;
                nick = reg_nick;
            end else begin
                dt = reg_dt;
            end
        end
    end
endmodule

// File: rtl/regfile.sv
// Register file + rename table: updates at posedge when rdy, two 0-cycle operand lookups.
// rdy low freezes state; lookups keep reflecting current state.
module regfile
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iclr,
    input  logic              iROB_nick_en,
    input  logic [NICK_W-1:0] iROB_nick,
    input  logic [NAME_W-1:0] iROB_nick_regnm,
    input  logic              iROB_en,
    input  logic [NAME_W-1:0] iROB_rd_regnm,
    input  logic [DATA_W-1:0] iROB_rd_dt,
    input  logic [NICK_W-1:0] iROB_rd_nick,
    input  logic [NAME_W-1:0] iDP_rs1_regnm,
    input  logic [NAME_W-1:0] iDP_rs2_regnm,
    output logic              oDP_rs1_busy,
    output logic              oDP_rs2_busy,
    output logic [NICK_W-1:0] oDP_rs1_nick,
    output logic [NICK_W-1:0] oDP_rs2_nick,
    output logic [DATA_W-1:0] oDP_rs1_dt,
    output logic [DATA_W-1:0] oDP_rs2_dt
);
    logic [DATA_W-1:0] dt_q   [REG_NUM];
    logic [NICK_W-1:0] nick_q [REG_NUM];
    logic [REG_NUM-1:0] busy_q;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                dt_q[i]   <= '0;
                nick_q[i] <= ZERO_NICK;
            end
        end else if (rdy) begin
            if (iclr) begin
                busy_q <= '0;
                for (int i = 0; i < REG_NUM; i++) nick_q[i] <= ZERO_NICK;
            end
            if (iROB_en && iROB_rd_regnm != '0) begin
                dt_q[iROB_rd_regnm] <= iROB_rd_dt;
                if (!iclr && busy_q[iROB_rd_regnm] && nick_q[iROB_rd_regnm] == iROB_rd_nick) begin
                    busy_q[iROB_rd_regnm] <= 1'b0;
                    nick_q[iROB_rd_regnm] <= ZERO_NICK;
                end
            end
            // Placed last so a same-cycle rename overrides the commit's busy clear.
            if (iROB_nick_en && iROB_nick_regnm != '0 && !iclr) begin
                busy_q[iROB_nick_regnm] <= 1'b1;
                nick_q[iROB_nick_regnm] <= iROB_nick;
            end
        end
    end

    regfile_lookup u_rs1 (
        .regnm    (iDP_rs1_regnm),
        .cm_en    (iROB_en),
        .cm_regnm (iROB_rd_regnm),
        .cm_nick  (iROB_rd_nick),
        .cm_dt    (iROB_rd_dt),
        .reg_busy (busy_q[iDP_rs1_regnm]),
        .reg_nick (nick_q[iDP_rs1_regnm]),
        .reg_dt   (dt_q[iDP_rs1_regnm]),
        .busy     (oDP_rs1_busy),
        .nick     (oDP_rs1_nick),
        .dt       (oDP_rs1_dt)
    );

    regfile_lookup u_rs2 (
        .regnm    (iDP_rs2_regnm),
        .cm_en    (iROB_en),
        .cm_regnm (iROB_rd_regnm),
        .cm_nick  (iROB_rd_nick),
        .cm_dt    (iROB_rd_dt),
        .reg_busy (busy_q[iDP_rs2_regnm]),
        .reg_nick (nick_q[iDP_rs2_regnm]),
        .reg_dt   (dt_q[iDP_rs2_regnm]),
        .busy     (oDP_rs2_busy),
        .nick     (oDP_rs2_nick),
        .dt       (oDP_rs2_dt)
    );
endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: expected lookups are queued as stimulus is driven, then popped and checked.
module tb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        iclr;
    logic        iROB_nick_en;
    logic [4:0]  iROB_nick;
    logic [4:0]  iROB_nick_regnm;
    logic        iROB_en;
    logic [4:0]  iROB_rd_regnm;
    logic [31:0] iROB_rd_dt;
    logic [4:0]  iROB_rd_nick;
    logic [4:0]  iDP_rs1_regnm;
    logic [4:0]  iDP_rs2_regnm;
    logic        oDP_rs1_busy;
    logic        oDP_rs2_busy;
    logic [4:0]  oDP_rs1_nick;
    logic [4:0]  oDP_rs2_nick;
    logic [31:0] oDP_rs1_dt;
    logic [31:0] oDP_rs2_dt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        bit          port;
        logic [37:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    regfile dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .iclr            (iclr),
        .iROB_nick_en    (iROB_nick_en),
        .iROB_nick       (iROB_nick),
        .iROB_nick_regnm (iROB_nick_regnm),
        .iROB_en         (iROB_en),
        .iROB_rd_regnm   (iROB_rd_regnm),
        .iROB_rd_dt      (iROB_rd_dt),
        .iROB_rd_nick    (iROB_rd_nick),
        .iDP_rs1_regnm   (iDP_rs1_regnm),
        .iDP_rs2_regnm   (iDP_rs2_regnm),
        .oDP_rs1_busy    (oDP_rs1_busy),
        .oDP_rs2_busy    (oDP_rs2_busy),
        .oDP_rs1_nick    (oDP_rs1_nick),
        .oDP_rs2_nick    (oDP_rs2_nick),
        .oDP_rs1_dt      (oDP_rs1_dt),
        .oDP_rs2_dt      (oDP_rs2_dt)
    );

    task automatic idle();
        iclr = 1'b0; iROB_nick_en = 1'b0; iROB_nick = '0; iROB_nick_regnm = '0;
        iROB_en = 1'b0; iROB_rd_regnm = '0; iROB_rd_dt = '0; iROB_rd_nick = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rename(input logic [4:0] rn, input logic [4:0] nk);
        iROB_nick_en = 1'b1; iROB_nick_regnm = rn; iROB_nick = nk;
    endtask

    task automatic commit(input logic [4:0] rn, input logic [31:0] d, input logic [4:0] nk);
        iROB_en = 1'b1; iROB_rd_regnm = rn; iROB_rd_dt = d; iROB_rd_nick = nk;
    endtask

    task automatic expect_rs(input string tag, input bit port, input logic b,
                             input logic [4:0] n, input logic [31:0] d);
        exp_t e;
        e.tag = tag; e.port = port; e.val = {b, n, d};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [37:0] obs;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? {oDP_rs2_busy, oDP_rs2_nick, oDP_rs2_dt}
                         : {oDP_rs1_busy, oDP_rs1_nick, oDP_rs1_dt};
            tests++;
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s rs%0d busy/nick/dt observed=%b/%0d/%h expected=%b/%0d/%h",
                       e.tag, e.port ? 2 : 1, obs[37], obs[36:32], obs[31:0],
                       e.val[37], e.val[36:32], e.val[31:0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; idle();
        iDP_rs1_regnm = 5'd5; iDP_rs2_regnm = 5'd0;
        #2;
        expect_rs("reset_x5", 0, 1'b0, 5'd0, 32'h0);
        expect_rs("reset_x0", 1, 1'b0, 5'd0, 32'h0);
        check();
        #10 rst = 1'b0;

        // Plain commit without rename
        commit(5'd5, 32'hDEADBEEF, 5'd3);
        tick(); idle();
        iDP_rs1_regnm = 5'd5;
        expect_rs("commit_x5", 0, 1'b0, 5'd0, 32'hDEADBEEF);
        check();

        // Rename then commit with bypass
        rename(5'd7, 5'd4);
        tick(); idle();
        iDP_rs1_regnm = 5'd7;
        expect_rs("rename_x7", 0, 1'b1, 5'd4, 32'h0);
        check();
        commit(5'd7, 32'h11, 5'd4);
        expect_rs("bypass_x7", 0, 1'b0, 5'd0, 32'h11);
        check();
        tick(); idle();
        expect_rs("after_commit_x7", 0, 1'b0, 5'd0, 32'h11);
        check();

        // Younger rename survives an older commit
        rename(5'd7, 5'd4); tick(); idle();
        rename(5'd7, 5'd9); tick(); idle();
        commit(5'd7, 32'h22, 5'd4);
        iDP_rs2_regnm = 5'd7;
        expect_rs("stale_commit_nobypass", 1, 1'b1, 5'd9, 32'h0);
        check();
        tick(); idle();
        expect_rs("stale_commit_busy", 1, 1'b1, 5'd9, 32'h0);
        check();
        commit(5'd7, 32'h33, 5'd9);
        tick(); idle();
        expect_rs("young_commit", 1, 1'b0, 5'd0, 32'h33);
        check();

        // Flush with same-cycle commit and dropped rename
        commit(5'd4, 32'h55, 5'd2); tick(); idle();
        rename(5'd3, 5'd6); tick(); idle();
        rename(5'd4, 5'd7); tick(); idle();
        iclr = 1'b1; commit(5'd3, 32'h44, 5'd6); rename(5'd4, 5'd8);
        iDP_rs1_regnm = 5'd3; iDP_rs2_regnm = 5'd4;
        expect_rs("clr_cycle_x3_bypass", 0, 1'b0, 5'd0, 32'h44);
        expect_rs("clr_cycle_x4_busy", 1, 1'b1, 5'd7, 32'h0);
        check();
        tick(); idle();
        expect_rs("post_clr_x3", 0, 1'b0, 5'd0, 32'h44);
        expect_rs("post_clr_x4", 1, 1'b0, 5'd0, 32'h55);
        check();

        // x0 is immune to rename and commit
        rename(5'd0, 5'd5); commit(5'd0, 32'h99, 5'd5);
        iDP_rs1_regnm = 5'd0;
        expect_rs("x0_same_cycle", 0, 1'b0, 5'd0, 32'h0);
        check();
        tick(); idle();
        expect_rs("x0_after", 0, 1'b0, 5'd0, 32'h0);
        check();

        // rdy low freezes state
        rdy = 1'b0;
        rename(5'd2, 5'd5); commit(5'd5, 32'h77, 5'd1);
        tick(); idle();
        iDP_rs1_regnm = 5'd2; iDP_rs2_regnm = 5'd5;
        expect_rs("rdy0_rename_x2", 0, 1'b0, 5'd0, 32'h0);
        expect_rs("rdy0_commit_x5", 1, 1'b0, 5'd0, 32'hDEADBEEF);
        check();
        rdy = 1'b1;
        rename(5'd2, 5'd5); tick(); idle();
        expect_rs("rdy1_rename_x2", 0, 1'b1, 5'd5, 32'h0);
        check();

        // Asynchronous reset mid-cycle
        #2 rst = 1'b1;
        expect_rs("async_rst_x2", 0, 1'b0, 5'd0, 32'h0);
        expect_rs("async_rst_x5", 1, 1'b0, 5'd0, 32'h0);
        check();
        #1 rst = 1'b0;
        tick();
        iDP_rs2_regnm = 5'd7;
        expect_rs("post_rst_x2", 0, 1'b0, 5'd0, 32'h0);
        expect_rs("post_rst_x7", 1, 1'b0, 5'd0, 32'h0);
        check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
